// File: rtl/los_qual_pkg.sv
// Shared types and defaults for the LOS qualifier. The optional assert-event
// counters are enabled by defining LOS_QUAL_TRANS_CNT_EN.
package los_qual_pkg;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        PEND_LOS = 2'd1,
        LOS      = 2'd2,
        PEND_OK  = 2'd3
    } los_state_e;

    localparam int   DEF_NUMCH    = 24;
    localparam int   DEF_DBWIDTH  = 16;
    localparam int   DEF_CNTWIDTH = 16;
    localparam logic RST_LEVEL    = 1'b1;

endpackage

// File: rtl/los_qual_chan.sv
// One LOS channel: synchroniser, assert/deassert debounce FSM, sticky change bit
// and, when LOS_QUAL_TRANS_CNT_EN is defined, a saturating assert-event counter.
module los_qual_chan
    import los_qual_pkg::*;
#(
    parameter int pDBWIDTH  = DEF_DBWIDTH,
    parameter int pCNTWIDTH = DEF_CNTWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 los_raw,
    input  logic [pDBWIDTH-1:0]  assert_th,
    input  logic [pDBWIDTH-1:0]  deassert_th,
    input  logic                 sticky_clr,
    input  logic                 cnt_clr,
    output logic                 deb,
    output logic                 deb_reg,
    output logic                 sticky,
    output logic [pCNTWIDTH-1:0] cnt
);
    function automatic logic [pDBWIDTH-1:0] sat_inc_db(input logic [pDBWIDTH-1:0] v);
        return (&v) ? v : v + pDBWIDTH'(1);
    endfunction

    function automatic logic [pCNTWIDTH-1:0] sat_inc_cnt(input logic [pCNTWIDTH-1:0] v);
        return (&v) ? v : v + pCNTWIDTH'(1);
    endfunction

    logic                sync_p0, sync_p1;
    los_state_e          state, state_nx;
    logic [pDBWIDTH-1:0] dcnt, dcnt_nx;

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= RST_LEVEL;
            sync_p1 <= RST_LEVEL;
        end else begin
            sync_p0 <= los_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounce FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOS;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        case (state)
            OK: if (sync_p1) begin
                state_nx = (assert_th == '0) ? LOS : PEND_LOS;
                dcnt_nx  = (assert_th == '0) ? '0 : pDBWIDTH'(1);
            end
            PEND_LOS: begin
                if (!sync_p1) begin
                    state_nx = OK;
                    dcnt_nx  = '0;
                end else if (dcnt >= assert_th) begin
                    state_nx = LOS;
                    dcnt_nx  = '0;
                end else begin
                    dcnt_nx  = sat_inc_db(dcnt);
                end
            end
            LOS: if (!sync_p1) begin
                state_nx = (deassert_th == '0) ? OK : PEND_OK;
                dcnt_nx  = (deassert_th == '0) ? '0 : pDBWIDTH'(1);
            end
            PEND_OK: begin
                if (sync_p1) begin
                    state_nx = LOS;
                    dcnt_nx  = '0;
                end else if (dcnt >= deassert_th) begin
                    state_nx = OK;
                    dcnt_nx  = '0;
                end else begin
                    dcnt_nx  = sat_inc_db(dcnt);
                end
            end
            default: begin
                state_nx = LOS;
                dcnt_nx  = '0;
            end
        endcase
    end

    assign deb = (state == LOS) || (state == PEND_OK);

    // Stage p3: registered debounced state and sticky; a fresh set beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_reg <= RST_LEVEL;
            sticky  <= 1'b0;
        end else begin
            deb_reg <= deb;
            sticky  <= (deb != deb_reg) | (sticky & ~sticky_clr);
        end
    end

`ifdef LOS_QUAL_TRANS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (deb && !deb_reg) begin
            cnt <= cnt_clr ? pCNTWIDTH'(1) : sat_inc_cnt(cnt);
        end else if (cnt_clr) begin
            cnt <= '0;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt            = '0;
`endif

endmodule

// File: rtl/los_qual_ctrl.sv
// Per-channel LOS qualifier top: force mux, IRQ reduction and counter readback.
// Event counters are built only when LOS_QUAL_TRANS_CNT_EN is defined.
module los_qual_ctrl
    import los_qual_pkg::*;
#(
    parameter int pNUMCH    = DEF_NUMCH,
    parameter int pDBWIDTH  = DEF_DBWIDTH,
    parameter int pCNTWIDTH = DEF_CNTWIDTH
) (
    input  logic                 iCLK_100M,
    input  logic                 iRST_100M,
    input  logic [pNUMCH-1:0]    iLOS,
    input  logic [pNUMCH-1:0]    iREG_FORCE_EN,
    input  logic [pNUMCH-1:0]    iREG_FORCE_VALUE,
    input  logic [pDBWIDTH-1:0]  iREG_ASSERT_TH,
    input  logic [pDBWIDTH-1:0]  iREG_DEASSERT_TH,
    input  logic [pNUMCH-1:0]    iREG_IRQ_MASK,
    input  logic [pNUMCH-1:0]    iREG_STICKY_CLR,
    input  logic [5:0]           iREG_CNT_SEL,
    input  logic                 iREG_CNT_CLR,
    output logic [pNUMCH-1:0]    oLOS_QUAL,
    output logic [pNUMCH-1:0]    oREG_LOS_DEB,
    output logic [pNUMCH-1:0]    oREG_STICKY_CHG,
    output logic [pCNTWIDTH-1:0] oREG_TRANS_CNT,
    output logic                 oIRQ
);
    logic [pNUMCH-1:0]                deb, cnt_clr;
    logic [pNUMCH-1:0][pCNTWIDTH-1:0] cnt_all;

    for (genvar i = 0; i < pNUMCH; i++) begin : g_chan
`ifdef LOS_QUAL_TRANS_CNT_EN
        assign cnt_clr[i] = iREG_CNT_CLR && (iREG_CNT_SEL == 6'(i));
`else
        assign cnt_clr[i] = 1'b0;
`endif
        los_qual_chan #(
            .pDBWIDTH  (pDBWIDTH),
            .pCNTWIDTH (pCNTWIDTH)
        ) u_chan (
            .clk         (iCLK_100M),
            .rst         (iRST_100M),
            .los_raw     (iLOS[i]),
            .assert_th   (iREG_ASSERT_TH),
            .deassert_th (iREG_DEASSERT_TH),
            .sticky_clr  (iREG_STICKY_CLR[i]),
            .cnt_clr     (cnt_clr[i]),
            .deb         (deb[i]),
            .deb_reg     (oREG_LOS_DEB[i]),
            .sticky      (oREG_STICKY_CHG[i]),
            .cnt         (cnt_all[i])
        );
    end

    // Stage p3: force mux and IRQ; forcing never disturbs the FSM underneath
    always_ff @(posedge iCLK_100M) begin
        if (iRST_100M) begin
            oLOS_QUAL <= {pNUMCH{RST_LEVEL}};
            oIRQ      <= 1'b0;
        end else begin
            oLOS_QUAL <= (iREG_FORCE_EN & iREG_FORCE_VALUE) | (~iREG_FORCE_EN & deb);
            oIRQ      <= |(oREG_STICKY_CHG & iREG_IRQ_MASK);
        end
    end

`ifdef LOS_QUAL_TRANS_CNT_EN
    logic [pCNTWIDTH-1:0] sel_cnt;

    // Out-of-range selects fall through to zero
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < pNUMCH; i++) begin
            if (iREG_CNT_SEL == 6'(i)) sel_cnt = cnt_all[i];
        end
    end

    always_ff @(posedge iCLK_100M) begin
        if (iRST_100M) oREG_TRANS_CNT <= '0;
        else           oREG_TRANS_CNT <= sel_cnt;
    end
`else
    logic unused_cnt;
    assign unused_cnt     = ^{iREG_CNT_SEL, iREG_CNT_CLR, cnt_all};
    assign oREG_TRANS_CNT = '0;
`endif

endmodule
